// File: rtl/instr_mem_v2.sv
// -----------------------------------------------------------------------------
// instr_mem_v2 -- instruction memory with an internal fetch pointer
//
// Holds DEPTH words of DATA_W bits and streams them out one per fetch, with
// a one-entry valid/ready output register. A redirect reloads the fetch
// pointer and flushes the presented instruction. The memory can be written
// at any time through a separate program-load port.
//
// Optional feature macro: INSTR_MEM_PRELOAD_EN
//   defined   -> memory starts with a repeating 3-instruction test program
//   undefined -> memory starts with NOP (32'h00000013) in every word
//
// Ports
//   clock           in   single clock, rising edge
//   reset_n         in   asynchronous active-low reset (memory untouched)
//   next_op         in   fetch request
//   instr_ready     in   downstream accepts the presented instruction
//   redirect_valid  in   load redirect_addr into the fetch pointer, flush
//   redirect_addr   in   new fetch word address (>= DEPTH maps to 0)
//   wr_en           in   program-load write strobe
//   wr_addr         in   write word address (>= DEPTH ignored)
//   wr_data         in   write data
//   instr           out  registered instruction word
//   instr_addr      out  word address instr was read from
//   instr_valid     out  instr/instr_addr hold an unconsumed instruction
//   wrap            out  one-cycle pulse after a fetch from DEPTH-1
// -----------------------------------------------------------------------------
module instr_mem_v2 #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              next_op,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    output logic              wrap
);

    // Index width of the storage array; ADDR_W may be wider than this, but
    // every address used as an index has already been range-checked.
    localparam int               IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef INSTR_MEM_PRELOAD_EN
            case (i % 3)
                0:       m[i] = DATA_W'(32'h00A0_0093);
                1:       m[i] = DATA_W'(32'h0010_8133);
                default: m[i] = DATA_W'(32'h0020_8203);
            endcase
`else
            m[i] = DATA_W'(32'h0000_0013);
`endif
        end
        return m;
    endfunction

    // Power-up contents come from the declaration; there is no run-time
    // initialisation path.
    mem_t mem_q = mem_init();

    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              valid_q, valid_d;
    logic              wrap_q,  wrap_d;
    logic              fetch;

    // A presented-but-unaccepted instruction blocks new fetches; a redirect
    // always wins over both fetch and accept.
    assign fetch = next_op && !redirect_valid && (!valid_q || instr_ready);

    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it
        // unassigned, which would otherwise infer a latch.
        pc_d    = pc_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;

        if (redirect_valid) begin
            pc_d    = (redirect_addr > LAST_ADDR) ? '0 : redirect_addr;
            valid_d = 1'b0;
        end else if (fetch) begin
            instr_d = mem_q[pc_q[IDX_W-1:0]];
            addr_d  = pc_q;
            valid_d = 1'b1;
            wrap_d  = (pc_q == LAST_ADDR);
            pc_d    = (pc_q == LAST_ADDR) ? '0 : pc_q + ADDR_W'(1);
        end else if (valid_q && instr_ready) begin
            // Consumed with nothing behind it: drop valid, keep the data.
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is also what makes a same-cycle write
    // and fetch of one address return the old word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    // NOTE: the storage array is deliberately left out of reset so that a
    // reset keeps the loaded program and the array maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (wr_en && (wr_addr <= LAST_ADDR)) begin
            mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    assign instr       = instr_q;
    assign instr_addr  = addr_q;
    assign instr_valid = valid_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_instr_mem_v2.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_v2 -- self-checking bench for instr_mem_v2
//
// Directed scenarios (streaming, back-pressure, wrap, redirect, same-cycle
// write/fetch, out-of-range write, mid-stream reset) followed by a random
// phase, all compared every cycle against a behavioural model. ADDR_W is
// widened to 7 so addresses >= DEPTH can actually be presented.
// Follows the INSTR_MEM_PRELOAD_EN setting for the initial memory image.
// -----------------------------------------------------------------------------
module tb_instr_mem_v2;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 7;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              next_op;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic              wrap;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_pc;
    logic [DATA_W-1:0] m_instr;
    int                m_addr;
    bit                m_valid;
    bit                m_wrap;

    instr_mem_v2 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .next_op        (next_op),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .instr          (instr),
        .instr_addr     (instr_addr),
        .instr_valid    (instr_valid),
        .wrap           (wrap)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] init_word(int a);
`ifdef INSTR_MEM_PRELOAD_EN
        if (a % 3 == 0) return 32'h00A0_0093;
        if (a % 3 == 1) return 32'h0010_8133;
        return 32'h0020_8203;
`else
        return 32'h0000_0013;
`endif
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        check({tag, ".instr"}, 64'(instr),       64'(m_instr));
        check({tag, ".addr"},  64'(instr_addr),  64'(m_addr));
        check({tag, ".valid"}, 64'(instr_valid), 64'(m_valid));
        check({tag, ".wrap"},  64'(wrap),        64'(m_wrap));
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = '0; m_addr = 0; m_valid = 0; m_wrap = 0;
    endtask

    // One clock: work out the model's next state from the inputs as they
    // stand before the edge, then compare just after the edge.
    task automatic cycle(string tag);
        bit                f;
        int                n_pc    = m_pc;
        logic [DATA_W-1:0] n_instr = m_instr;
        int                n_addr  = m_addr;
        bit                n_valid = m_valid;
        bit                n_wrap  = 0;
        f = next_op && !redirect_valid && (!m_valid || instr_ready);
        if (redirect_valid) begin
            n_pc    = (int'(redirect_addr) >= DEPTH) ? 0 : int'(redirect_addr);
            n_valid = 0;
        end else if (f) begin
            n_instr = m_mem[m_pc];
            n_addr  = m_pc;
            n_valid = 1;
            n_wrap  = (m_pc == DEPTH - 1);
            n_pc    = (m_pc + 1) % DEPTH;
        end else if (m_valid && instr_ready) begin
            n_valid = 0;
        end
        @(posedge clock);
        #1;
        if (wr_en && int'(wr_addr) < DEPTH) m_mem[int'(wr_addr)] = wr_data;
        m_pc = n_pc; m_instr = n_instr; m_addr = n_addr;
        m_valid = n_valid; m_wrap = n_wrap;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        next_op = 0; instr_ready = 0; redirect_valid = 0; redirect_addr = '0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = init_word(i);
        model_reset();
        idle_inputs();
        reset_n = 0;

        // Reset state.
        #12;
        check_outputs("reset");
        reset_n = 1;

        // Stream four instructions from address 0.
        next_op = 1; instr_ready = 1;
        for (int i = 0; i < 4; i++) cycle("stream");

        // Reach address 5, stall three cycles, then release.
        cycle("to5");
        cycle("at5");
        instr_ready = 0;
        for (int i = 0; i < 3; i++) cycle("stall");
        check("stall.addr5", 64'(instr_addr), 64'd5);
        instr_ready = 1;
        cycle("release");

        // Run through DEPTH-1 and past the wrap.
        for (int i = 0; i < DEPTH; i++) cycle("wraprun");

        // Redirect with a simultaneous fetch request, then fetch.
        redirect_valid = 1; redirect_addr = 7'd10;
        cycle("redir10");
        redirect_valid = 0;
        cycle("fetch10");
        check("fetch10.addr", 64'(instr_addr), 64'd10);

        // Out-of-range redirect lands on 0.
        redirect_valid = 1; redirect_addr = 7'd70;
        cycle("redir70");
        redirect_valid = 0;
        cycle("fetch70");
        check("fetch70.addr", 64'(instr_addr), 64'd0);

        // Same-cycle write and fetch of address 4 returns the old word.
        redirect_valid = 1; redirect_addr = 7'd4;
        cycle("redir4");
        redirect_valid = 0;
        wr_en = 1; wr_addr = 7'd4; wr_data = 32'hDEAD_BEEF;
        cycle("wrfetch4");
        wr_en = 0;
        redirect_valid = 1;
        cycle("redir4b");
        redirect_valid = 0;
        cycle("refetch4");
        check("refetch4.data", 64'(instr), 64'h0000_0000_DEAD_BEEF);

        // Out-of-range write must not alias onto address 36.
        next_op = 0;
        wr_en = 1; wr_addr = 7'd100; wr_data = 32'h1234_5678;
        cycle("wr100");
        wr_en = 0; next_op = 1;
        redirect_valid = 1; redirect_addr = 7'd36;
        cycle("redir36");
        redirect_valid = 0;
        cycle("fetch36");

        // Mid-stream asynchronous reset with a held instruction.
        instr_ready = 0;
        cycle("hold");
        #3 reset_n = 0;
        #1;
        model_reset();
        check_outputs("midreset");
        #2 reset_n = 1;
        instr_ready = 1;
        cycle("afterreset");
        check("afterreset.addr", 64'(instr_addr), 64'd0);
        redirect_valid = 1; redirect_addr = 7'd4;
        cycle("redir4c");
        redirect_valid = 0;
        cycle("retain4");
        check("retain4.data", 64'(instr), 64'h0000_0000_DEAD_BEEF);

        // Random phase.
        for (int i = 0; i < 400; i++) begin
            next_op        = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_addr  = ADDR_W'($urandom_range(0, 127));
            wr_en          = ($urandom_range(0, 4) == 0);
            wr_addr        = ADDR_W'($urandom_range(0, 127));
            wr_data        = $urandom;
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
